// File: rtl/fifo_ptr_pkg.sv
// Shared pointer definitions for the dual-clock FIFO pointer handlers.
// Holds the default pointer geometry, the pointer type and the Gray/binary conversion helpers.
// Write and read handlers use the same definitions, so both domains agree on pointer width.
package fifo_ptr_pkg;

    localparam int unsigned PTR_WIDTH = 3;
    localparam int unsigned DEPTH     = 2 ** PTR_WIDTH;

    // Pointer carries one extra wrap bit above the RAM address.
    typedef logic [PTR_WIDTH:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t v);
        return (v >> 1) ^ v;
    endfunction

    function automatic ptr_t gray2bin(input ptr_t v);
        ptr_t b;
        b = '0;
        for (int i = 0; i <= int'(PTR_WIDTH); i++) begin
            b[i] = ^(v >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Shared by the write- and read-side pointer handlers.
// Ports:
//   gray  in   WIDTH  Gray-coded value
//   bin   out  WIDTH  binary equivalent
module gray2bin_conv #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each binary bit is the parity of all Gray bits at or above it.
    always_comb begin
        bin = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/wptr_full_handler.sv
// Write-domain pointer and flag controller of the dual-clock async FIFO.
// Owns the binary and Gray write pointers, registered full / almost_full, an occupancy
// estimate and a sticky overflow flag. Every output comes straight from a flop.
// Ports:
//   wclk         in   1            write clock
//   wrst         in   1            asynchronous reset, active-low
//   w_en         in   1            write request
//   ovf_clr      in   1            clears sticky overflow (a same-cycle dropped write wins)
//   g_rptr_sync  in   PTR_WIDTH+1  read pointer, Gray, already synchronised into wclk
//   b_wptr       out  PTR_WIDTH+1  binary write pointer; low PTR_WIDTH bits address the RAM
//   g_wptr       out  PTR_WIDTH+1  Gray write pointer for the read-domain synchroniser
//   full         out  1            FIFO full
//   almost_full  out  1            level >= DEPTH - AF_MARGIN
//   wr_level     out  PTR_WIDTH+1  occupancy estimate, 0..DEPTH
//   overflow     out  1            sticky: a write was attempted while full
module wptr_full_handler #(
    parameter int unsigned PTR_WIDTH = 3,
    parameter int unsigned AF_MARGIN = 1
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 w_en,
    input  logic                 ovf_clr,
    input  logic [PTR_WIDTH:0]   g_rptr_sync,
    output logic [PTR_WIDTH:0]   b_wptr,
    output logic [PTR_WIDTH:0]   g_wptr,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   wr_level,
    output logic                 overflow
);

    import fifo_ptr_pkg::*;

    localparam logic [PTR_WIDTH:0] AfThresh = (PTR_WIDTH + 1)'(2 ** PTR_WIDTH - AF_MARGIN);

    logic               wr_acc;
    logic [PTR_WIDTH:0] b_wptr_next;
    logic [PTR_WIDTH:0] g_wptr_next;
    logic [PTR_WIDTH:0] b_rptr_sync;
    logic [PTR_WIDTH:0] g_rptr_full;
    logic [PTR_WIDTH:0] level_next;
    logic               full_next;
    logic               af_next;
    logic               ovf_next;

    gray2bin_conv #(
        .WIDTH (PTR_WIDTH + 1)
    ) u_rptr_conv (
        .gray (g_rptr_sync),
        .bin  (b_rptr_sync)
    );

    always_comb begin
        wr_acc      = w_en & ~full;
        b_wptr_next = b_wptr + {{PTR_WIDTH{1'b0}}, wr_acc};
        g_wptr_next = (b_wptr_next >> 1) ^ b_wptr_next;
        // Full when the write pointer is exactly one lap ahead: in Gray code that is the
        // read pointer with its two top bits inverted.
        g_rptr_full = {~g_rptr_sync[PTR_WIDTH:PTR_WIDTH-1], g_rptr_sync[PTR_WIDTH-2:0]};
        full_next   = (g_wptr_next == g_rptr_full);
        // Modular difference stays correct across the pointer wrap.
        level_next  = b_wptr_next - b_rptr_sync;
        af_next     = (level_next >= AfThresh);
        // A dropped write sets overflow even if a clear arrives in the same cycle.
        ovf_next    = (w_en & full) | (overflow & ~ovf_clr);
    end

    always_ff @(posedge wclk or negedge wrst) begin
        if (!wrst) begin
            b_wptr      <= '0;
            g_wptr      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            b_wptr      <= b_wptr_next;
            g_wptr      <= g_wptr_next;
            full        <= full_next;
            almost_full <= af_next;
            wr_level    <= level_next;
            overflow    <= ovf_next;
        end
    end

endmodule

// File: tb/tb_wptr_full_handler.sv
// Scoreboard bench for wptr_full_handler (PTR_WIDTH=3, AF_MARGIN=1).
// Stimulus pushes the hand-computed expected outputs for each cycle; a monitor pops and
// compares them one wclk edge later.
module tb_wptr_full_handler;

    import fifo_ptr_pkg::*;

    localparam int unsigned PW = 3;

    logic          wclk = 1'b0;
    logic          wrst = 1'b0;
    logic          w_en = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [PW:0]   g_rptr_sync = '0;
    logic [PW:0]   b_wptr;
    logic [PW:0]   g_wptr;
    logic          full;
    logic          almost_full;
    logic [PW:0]   wr_level;
    logic          overflow;

    typedef struct {
        string       tag;
        logic [PW:0] b;
        logic [PW:0] g;
        logic [PW:0] lvl;
        logic        f;
        logic        af;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Hand-computed Gray codes of 1..8.
    int fill_g[8] = '{1, 3, 2, 6, 7, 5, 4, 12};

    wptr_full_handler #(
        .PTR_WIDTH (PW),
        .AF_MARGIN (1)
    ) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .w_en        (w_en),
        .ovf_clr     (ovf_clr),
        .g_rptr_sync (g_rptr_sync),
        .b_wptr      (b_wptr),
        .g_wptr      (g_wptr),
        .full        (full),
        .almost_full (almost_full),
        .wr_level    (wr_level),
        .overflow    (overflow)
    );

    always #5 wclk = ~wclk;

    task automatic check_out(input exp_t e);
        total++;
        if (b_wptr !== e.b || g_wptr !== e.g || wr_level !== e.lvl || full !== e.f ||
            almost_full !== e.af || overflow !== e.ovf) begin
            bad++;
            $display("FAIL %s: got b=%0d g=%0d lvl=%0d full=%0b af=%0b ovf=%0b, want b=%0d g=%0d lvl=%0d full=%0b af=%0b ovf=%0b",
                     e.tag, b_wptr, g_wptr, wr_level, full, almost_full, overflow,
                     e.b, e.g, e.lvl, e.f, e.af, e.ovf);
        end
    endtask

    task automatic chk_zero(input string tag);
        exp_t e;
        e.tag = tag; e.b = '0; e.g = '0; e.lvl = '0; e.f = 1'b0; e.af = 1'b0; e.ovf = 1'b0;
        check_out(e);
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic we, input logic clr, input logic [PW:0] gr,
                        input string tag, input logic [PW:0] eb, input logic [PW:0] eg,
                        input logic [PW:0] el, input logic ef, input logic eaf,
                        input logic eovf);
        exp_t e;
        @(negedge wclk);
        w_en = we;
        ovf_clr = clr;
        g_rptr_sync = gr;
        e.tag = tag; e.b = eb; e.g = eg; e.lvl = el; e.f = ef; e.af = eaf; e.ovf = eovf;
        q.push_back(e);
    endtask

    // Monitor: every edge presents a new output word.
    initial begin
        exp_t e;
        forever begin
            @(posedge wclk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_out(e);
            end
        end
    end

    initial begin
        ptr_t b;
        ptr_t r;

        // Reset held with a write request pending.
        wrst = 1'b0;
        w_en = 1'b1;
        #22;
        chk_zero("reset_hold");
        @(negedge wclk);
        w_en = 1'b0;
        wrst = 1'b1;
        step(0, 0, 4'd0, "post_rst0", 0, 0, 0, 0, 0, 0);
        step(0, 0, 4'd0, "post_rst1", 0, 0, 0, 0, 0, 0);

        // Fill from empty.
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 4'd0, "fill", 4'(i + 1), 4'(fill_g[i]), 4'(i + 1), i == 7, i >= 6, 0);
        end

        // Writes while full are dropped; overflow sticky, set beats clear.
        step(1, 0, 4'd0, "ovf_w1", 8, 12, 8, 1, 1, 1);
        step(1, 0, 4'd0, "ovf_w2", 8, 12, 8, 1, 1, 1);
        step(0, 1, 4'd0, "ovf_clr", 8, 12, 8, 1, 1, 0);
        step(1, 1, 4'd0, "ovf_set_wins", 8, 12, 8, 1, 1, 1);
        step(0, 0, 4'd0, "ovf_hold", 8, 12, 8, 1, 1, 1);

        // One read arrives: full drops, next write refills.
        step(0, 0, 4'd1, "drain", 8, 12, 7, 0, 1, 1);
        step(1, 0, 4'd1, "drain_wr", 9, 13, 8, 1, 1, 1);
        step(0, 1, 4'd1, "drain_clr", 9, 13, 8, 1, 1, 0);
        step(0, 0, 4'd3, "pre_wrap", 9, 13, 7, 0, 1, 0);

        // Write and read advance together across the pointer wrap; level holds at 7.
        for (int i = 0; i < 20; i++) begin
            r = ptr_t'(3 + i);
            b = ptr_t'(10 + i);
            step(1, 0, bin2gray(r), "wrap", b, bin2gray(b), 7, 0, 1, 0);
        end

        // Async reset between edges with writes still requested.
        @(posedge wclk);
        #3;
        wrst = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge wclk);
        g_rptr_sync = '0;
        w_en = 1'b0;
        wrst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step(1, 0, 4'd0, "refill", 4'(i + 1), 4'(fill_g[i]), 4'(i + 1), i == 7, i >= 6, 0);
        end
        step(1, 0, 4'd0, "refill_ovf", 8, 12, 8, 1, 1, 1);
        step(0, 0, 4'd0, "idle", 8, 12, 8, 1, 1, 1);

        // Bounded drain of the scoreboard.
        repeat (3) @(posedge wclk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
